// File: rtl/core_pkg.sv
// core_pkg: shared state encoding and instruction constants for the core sequencer
package core_pkg;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_REQ  = 3'd1,
    FETCH_WAIT = 3'd2,
    EXEC       = 3'd3,
    HALT       = 3'd4,
    FAULT      = 3'd5
  } state_t;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
endpackage

// File: rtl/seq_counter.sv
// seq_counter: wrapping up-counter with synchronous clear and enable
module seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= q + 1'b1;
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/execute control FSM with fetch timeout and perf counters
module core_sequencer
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ir,
  input  logic             dec_reg_write,
  output logic             reg_wen,
  output logic             pc_wen,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  state_t st, nxt;
  logic [TO_W-1:0] to_cnt;
  logic in_fetch, ir_load, limit, is_brk;
  assign in_fetch = (st == FETCH_REQ) || (st == FETCH_WAIT);
  assign ir_load  = ((st == FETCH_REQ) && imem_ready && imem_rvalid) || ((st == FETCH_WAIT) && imem_rvalid);
  // limit marks the last permitted fetch cycle; a load in that cycle still wins
  assign limit    = in_fetch && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign is_brk   = ir == EBREAK;
  assign state    = st;
  assign halted   = st == HALT;
  assign fault    = st == FAULT;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      ir <= NOP;
    end else begin
      st <= nxt;
      if (ir_load) ir <= imem_rdata;
    end
  always_comb begin
    nxt      = st;
    imem_req = 1'b0;
    pc_wen   = 1'b0;
    reg_wen  = 1'b0;
    case (st)
      IDLE:       nxt = start ? FETCH_REQ : IDLE;
      FETCH_REQ: begin
        imem_req = 1'b1;
        nxt = ir_load ? EXEC : limit ? FAULT : imem_ready ? FETCH_WAIT : FETCH_REQ;
      end
      FETCH_WAIT: nxt = ir_load ? EXEC : limit ? FAULT : FETCH_WAIT;
      EXEC: begin
        pc_wen  = !is_brk;
        reg_wen = !is_brk && dec_reg_write;
        nxt     = is_brk ? HALT : FETCH_REQ;
      end
      default:    nxt = st;
    endcase
  end
  seq_counter #(.W(TO_W)) u_timeout (
    .clk(clk), .rst(rst), .clr(!in_fetch), .en(in_fetch), .q(to_cnt)
  );
  seq_counter #(.W(CNT_W)) u_cycle (
    .clk(clk), .rst(rst), .clr(1'b0), .en(in_fetch || st == EXEC), .q(cycle_cnt)
  );
  seq_counter #(.W(CNT_W)) u_instret (
    .clk(clk), .rst(rst), .clr(1'b0), .en(st == EXEC), .q(instret_cnt)
  );
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed scenario tests for core_sequencer with TIMEOUT_CYCLES=8
module tb_core_sequencer;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic imem_ready = 1'b0, imem_rvalid = 1'b0, dec_reg_write = 1'b1;
  logic [31:0] imem_rdata = '0;
  logic imem_req, reg_wen, pc_wen, halted, fault;
  logic [31:0] ir, cycle_cnt, instret_cnt;
  logic [2:0] state;
  int checks = 0, failures = 0;

  core_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .ir(ir), .dec_reg_write(dec_reg_write),
    .reg_wen(reg_wen), .pc_wen(pc_wen), .state(state), .halted(halted), .fault(fault),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; imem_ready = 0; imem_rvalid = 0; imem_rdata = '0; dec_reg_write = 1;
    rst = 0;
    cyc();
    cyc();
    rst = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (ir !== NOP) begin failures++; $display("FAIL reset_ir got=%h exp=%h", ir, NOP); end
    checks++; if ({imem_req, reg_wen, pc_wen, halted, fault} !== 5'b0) begin failures++; $display("FAIL reset_outs got=%b exp=00000", {imem_req, reg_wen, pc_wen, halted, fault}); end
    checks++; if (cycle_cnt !== 0 || instret_cnt !== 0) begin failures++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", cycle_cnt, instret_cnt); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] prog [4];
    int k, p, n;
    prog[0] = 32'h0010_0093; prog[1] = 32'h0020_0113; prog[2] = 32'h0030_8193; prog[3] = EBREAK;
    k = 0; p = 0; n = 0;
    do_reset();
    start = 1; imem_ready = 1; imem_rvalid = 1;
    while (!halted && n < 30) begin
      if (imem_req && k < 4) begin imem_rdata = prog[k]; k++; end
      cyc();
      n++;
      if (pc_wen) p++;
    end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL zw_halted got=%b exp=1 (cycles=%0d)", halted, n); end
    checks++; if (p != 3) begin failures++; $display("FAIL zw_pc_wen_pulses got=%0d exp=3", p); end
    checks++; if (instret_cnt !== 4) begin failures++; $display("FAIL zw_instret got=%0d exp=4", instret_cnt); end
    checks++; if (cycle_cnt !== 8) begin failures++; $display("FAIL zw_cycle_cnt got=%0d exp=8", cycle_cnt); end
    checks++; if (state !== 3'd4 || ir !== EBREAK) begin failures++; $display("FAIL zw_final got state=%0d ir=%h exp 4/%h", state, ir, EBREAK); end
  endtask

  task automatic test_wait_states();
    do_reset();
    start = 1; imem_rdata = 32'h0050_0093;
    cyc();
    checks++; if (state !== 3'd1 || imem_req !== 1'b1) begin failures++; $display("FAIL ws_req1 got state=%0d req=%b exp 1/1", state, imem_req); end
    cyc();
    imem_ready = 1;
    cyc();
    imem_ready = 0;
    checks++; if (state !== 3'd2 || imem_req !== 1'b0) begin failures++; $display("FAIL ws_wait got state=%0d req=%b exp 2/0", state, imem_req); end
    cyc();
    cyc();
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL ws_still_wait got=%0d exp=2", state); end
    imem_rvalid = 1;
    cyc();
    imem_rvalid = 0; imem_rdata = 32'hdead_beef;
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL ws_exec got=%0d exp=3", state); end
    checks++; if (ir !== 32'h0050_0093) begin failures++; $display("FAIL ws_ir got=%h exp=00500093", ir); end
    checks++; if (pc_wen !== 1'b1 || reg_wen !== 1'b1) begin failures++; $display("FAIL ws_strobes got pc=%b rw=%b exp 1/1", pc_wen, reg_wen); end
    cyc();
    checks++; if (state !== 3'd1 || cycle_cnt !== 6 || instret_cnt !== 1) begin failures++; $display("FAIL ws_after got state=%0d cyc=%0d ret=%0d exp 1/6/1", state, cycle_cnt, instret_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    start = 1;
    for (int i = 0; i < 8; i++) cyc();
    checks++; if (state !== 3'd1 || fault !== 1'b0) begin failures++; $display("FAIL to_before got state=%0d fault=%b exp 1/0", state, fault); end
    cyc();
    checks++; if (fault !== 1'b1 || state !== 3'd5) begin failures++; $display("FAIL to_fault got state=%0d fault=%b exp 5/1", state, fault); end
    checks++; if (ir !== NOP || imem_req !== 1'b0) begin failures++; $display("FAIL to_ir_req got ir=%h req=%b exp %h/0", ir, imem_req, NOP); end
    imem_ready = 1; imem_rvalid = 1; imem_rdata = 32'h0010_0093;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (state !== 3'd5 || imem_req !== 1'b0 || cycle_cnt !== 8) begin failures++; $display("FAIL to_sticky got state=%0d req=%b cyc=%0d exp 5/0/8", state, imem_req, cycle_cnt); end
    end
  endtask

  task automatic test_write_gating();
    do_reset();
    start = 1; imem_ready = 1; imem_rvalid = 1; imem_rdata = 32'h0011_2023; dec_reg_write = 0;
    cyc();
    cyc();
    checks++; if (state !== 3'd3 || pc_wen !== 1'b1 || reg_wen !== 1'b0) begin failures++; $display("FAIL wg_sw got state=%0d pc=%b rw=%b exp 3/1/0", state, pc_wen, reg_wen); end
    dec_reg_write = 1;
    #1;
    checks++; if (reg_wen !== 1'b1) begin failures++; $display("FAIL wg_rw_follow got=%b exp=1", reg_wen); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    start = 1; imem_ready = 1;
    cyc();
    cyc();
    imem_ready = 0;
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL rm_in_wait got=%0d exp=2", state); end
    imem_rvalid = 1; imem_rdata = 32'h0070_0093; rst = 0;
    #1;
    checks++; if (state !== 3'd0 || ir !== NOP || cycle_cnt !== 0 || instret_cnt !== 0) begin failures++; $display("FAIL rm_async got state=%0d ir=%h cyc=%0d ret=%0d exp 0/%h/0/0", state, ir, cycle_cnt, instret_cnt, NOP); end
    cyc();
    start = 0; imem_rvalid = 0; rst = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (state !== 3'd0 || pc_wen !== 1'b0 || instret_cnt !== 0 || ir !== NOP) begin failures++; $display("FAIL rm_no_exec got state=%0d pc=%b ret=%0d ir=%h exp 0/0/0/%h", state, pc_wen, instret_cnt, ir, NOP); end
    end
  endtask

  task automatic test_sticky_halt();
    do_reset();
    start = 1; imem_ready = 1; imem_rvalid = 1; imem_rdata = EBREAK;
    cyc();
    cyc();
    checks++; if (state !== 3'd3 || pc_wen !== 1'b0 || reg_wen !== 1'b0) begin failures++; $display("FAIL sh_exec_brk got state=%0d pc=%b rw=%b exp 3/0/0", state, pc_wen, reg_wen); end
    cyc();
    checks++; if (state !== 3'd4 || cycle_cnt !== 2 || instret_cnt !== 1) begin failures++; $display("FAIL sh_halt got state=%0d cyc=%0d ret=%0d exp 4/2/1", state, cycle_cnt, instret_cnt); end
    imem_rdata = 32'h0010_0093;
    for (int i = 0; i < 6; i++) begin
      start = i[0];
      cyc();
      checks++; if (state !== 3'd4 || {imem_req, pc_wen, reg_wen} !== 3'b0 || cycle_cnt !== 2) begin failures++; $display("FAIL sh_sticky got state=%0d strobes=%b cyc=%0d exp 4/000/2", state, {imem_req, pc_wen, reg_wen}, cycle_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_timeout();
    test_write_gating();
    test_reset_mid_fetch();
    test_sticky_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
